// File: rtl/uart_reg_pkg.sv
// Shared constants and types for the UART register block: CSR addresses, STATUS/CTRL/IRQ
// bit positions and the CTRL field layout.
package uart_reg_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 12'h000;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 12'h004;
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 12'h008;
  localparam logic [ADDR_W-1:0] ADDR_BAUD     = 12'h00C;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_EN   = 12'h010;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_STAT = 12'h014;

  localparam int unsigned STAT_TX_FULL  = 0;
  localparam int unsigned STAT_TX_EMPTY = 1;
  localparam int unsigned STAT_RX_FULL  = 2;
  localparam int unsigned STAT_RX_EMPTY = 3;
  localparam int unsigned STAT_RX_OVR   = 4;
  localparam int unsigned STAT_TX_OVF   = 5;
  localparam int unsigned STAT_TX_CNT   = 8;
  localparam int unsigned STAT_RX_CNT   = 16;

  localparam int unsigned CTRL_TX_FLUSH = 8;
  localparam int unsigned CTRL_RX_FLUSH = 9;

  localparam int unsigned IRQ_RX_NE    = 0;
  localparam int unsigned IRQ_TX_EMPTY = 1;
  localparam int unsigned IRQ_RX_OVR   = 2;
  localparam int unsigned IRQ_TX_OVF   = 3;

  // Level history after reset: TX FIFO starts empty, so that edge must not fire.
  localparam logic [3:0] IRQ_LVL_RST = 4'b0010;

  typedef struct packed {
    logic       rsvd;
    logic [1:0] dbits;
    logic       stop2;
    logic       par_odd;
    logic       par_en;
    logic       rx_en;
    logic       tx_en;
  } ctrl_t;

endpackage

// File: rtl/uart_reg_block_if.sv
// Register-slave bus and UART core handshakes of uart_reg_block.
// master = APB slave / UART core side, slave = register block.
interface uart_reg_block_if;
  import uart_reg_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr;
  logic              host_read_data;
  logic [DATA_W-1:0] rdata;
  logic              wadderr;
  logic              radderr;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [15:0]       baud_div;
  logic [7:0]        ctrl_o;
  logic              irq;

  modport master (
    output wr_en, waddr, wdata, raddr, host_read_data, tx_ready, rx_data, rx_valid,
    input  rdata, wadderr, radderr, tx_data, tx_valid, baud_div, ctrl_o, irq
  );

  modport slave (
    input  wr_en, waddr, wdata, raddr, host_read_data, tx_ready, rx_data, rx_valid,
    output rdata, wadderr, radderr, tx_data, tx_valid, baud_div, ctrl_o, irq
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with flush; push while full is only accepted alongside a pop.
// Pop while empty is ignored; a flush discards any same-cycle push/pop.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

  // Storage carries no reset; validity is tracked by the count.
  always_ff @(posedge pclk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_reg_block.sv
// UART CSR block: decodes slave-side accesses into DATA/STATUS/CTRL/BAUD and buffers TX/RX bytes.
// Define UART_REG_IRQ_EN to add IRQ_EN/IRQ_STAT and a registered irq; otherwise irq is tied 0.
module uart_reg_block
  import uart_reg_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16,
  parameter logic [15:0] BAUD_RST = 16'd27
) (
  input logic             pclk,
  input logic             preset,
  uart_reg_block_if.slave bus
);
  localparam int unsigned TxCw = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RxCw = $clog2(RX_DEPTH) + 1;

  ctrl_t       r_ctrl;
  logic [15:0] r_baud;
  logic        r_tx_ovf;
  logic        r_rx_ovr;
  logic        r_hrd;

  logic w_wr_data, w_wr_status, w_wr_ctrl, w_wr_baud, w_wr_valid;
  logic w_rd_data, w_rd_status, w_rd_ctrl, w_rd_baud, w_rd_valid;

  logic            w_tx_push, w_tx_pop, w_tx_flush, w_tx_full, w_tx_empty, w_tx_valid;
  logic [7:0]      w_tx_head;
  logic [TxCw-1:0] w_tx_count;
  logic            w_rx_push, w_rx_pop, w_rx_flush, w_rx_full, w_rx_empty;
  logic [7:0]      w_rx_head;
  logic [RxCw-1:0] w_rx_count;
  logic            w_tx_ovf_set, w_rx_ovr_set;
  logic [31:0]     w_status;
  logic            w_unused;

  assign w_wr_data   = bus.wr_en && (bus.waddr[11:2] == ADDR_DATA[11:2]);
  assign w_wr_status = bus.wr_en && (bus.waddr[11:2] == ADDR_STATUS[11:2]);
  assign w_wr_ctrl   = bus.wr_en && (bus.waddr[11:2] == ADDR_CTRL[11:2]);
  assign w_wr_baud   = bus.wr_en && (bus.waddr[11:2] == ADDR_BAUD[11:2]);
  assign w_rd_data   = (bus.raddr[11:2] == ADDR_DATA[11:2]);
  assign w_rd_status = (bus.raddr[11:2] == ADDR_STATUS[11:2]);
  assign w_rd_ctrl   = (bus.raddr[11:2] == ADDR_CTRL[11:2]);
  assign w_rd_baud   = (bus.raddr[11:2] == ADDR_BAUD[11:2]);

  assign w_unused = ^{bus.wdata[31:16], bus.waddr[1:0], bus.raddr[1:0]};

  assign w_tx_valid = !w_tx_empty && r_ctrl.tx_en;
  assign w_tx_push  = w_wr_data;
  assign w_tx_pop   = w_tx_valid && bus.tx_ready;
  assign w_tx_flush = w_wr_ctrl && bus.wdata[CTRL_TX_FLUSH];

  // Pop only on the rising edge of the read strobe so a held strobe consumes one byte.
  assign w_rx_push  = bus.rx_valid && r_ctrl.rx_en;
  assign w_rx_pop   = bus.host_read_data && !r_hrd && w_rd_data && !w_rx_empty;
  assign w_rx_flush = w_wr_ctrl && bus.wdata[CTRL_RX_FLUSH];

  assign w_tx_ovf_set = w_tx_push && w_tx_full && !w_tx_pop && !w_tx_flush;
  assign w_rx_ovr_set = w_rx_push && w_rx_full && !w_rx_pop && !w_rx_flush;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .pclk    (pclk),
    .preset  (preset),
    .i_push  (w_tx_push),
    .i_wdata (bus.wdata[7:0]),
    .i_pop   (w_tx_pop),
    .i_flush (w_tx_flush),
    .o_rdata (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .pclk    (pclk),
    .preset  (preset),
    .i_push  (w_rx_push),
    .i_wdata (bus.rx_data),
    .i_pop   (w_rx_pop),
    .i_flush (w_rx_flush),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_ctrl   <= '0;
      r_baud   <= BAUD_RST;
      r_tx_ovf <= 1'b0;
      r_rx_ovr <= 1'b0;
      r_hrd    <= 1'b0;
    end else begin
      r_hrd <= bus.host_read_data;
      if (w_wr_ctrl) r_ctrl <= ctrl_t'(bus.wdata[7:0]);
      if (w_wr_baud) r_baud <= bus.wdata[15:0];
      // A new overflow event wins over a same-cycle W1C.
      if (w_tx_ovf_set) begin
        r_tx_ovf <= 1'b1;
      end else if (w_wr_status && bus.wdata[STAT_TX_OVF]) begin
        r_tx_ovf <= 1'b0;
      end
      if (w_rx_ovr_set) begin
        r_rx_ovr <= 1'b1;
      end else if (w_wr_status && bus.wdata[STAT_RX_OVR]) begin
        r_rx_ovr <= 1'b0;
      end
    end
  end

  always_comb begin
    w_status                     = '0;
    w_status[STAT_TX_FULL]       = w_tx_full;
    w_status[STAT_TX_EMPTY]      = w_tx_empty;
    w_status[STAT_RX_FULL]       = w_rx_full;
    w_status[STAT_RX_EMPTY]      = w_rx_empty;
    w_status[STAT_RX_OVR]        = r_rx_ovr;
    w_status[STAT_TX_OVF]        = r_tx_ovf;
    w_status[STAT_TX_CNT +: 8]   = 8'(w_tx_count);
    w_status[STAT_RX_CNT +: 8]   = 8'(w_rx_count);
  end

`ifdef UART_REG_IRQ_EN
  logic       w_wr_irq_en, w_wr_irq_stat, w_rd_irq_en, w_rd_irq_stat;
  logic [3:0] r_irq_en, r_irq_stat, r_irq_lvl;
  logic [3:0] w_irq_lvl, w_irq_clr;
  logic       r_irq;

  assign w_wr_irq_en   = bus.wr_en && (bus.waddr[11:2] == ADDR_IRQ_EN[11:2]);
  assign w_wr_irq_stat = bus.wr_en && (bus.waddr[11:2] == ADDR_IRQ_STAT[11:2]);
  assign w_rd_irq_en   = (bus.raddr[11:2] == ADDR_IRQ_EN[11:2]);
  assign w_rd_irq_stat = (bus.raddr[11:2] == ADDR_IRQ_STAT[11:2]);

  always_comb begin
    w_irq_lvl               = '0;
    w_irq_lvl[IRQ_RX_NE]    = !w_rx_empty;
    w_irq_lvl[IRQ_TX_EMPTY] = w_tx_empty;
    w_irq_lvl[IRQ_RX_OVR]   = r_rx_ovr;
    w_irq_lvl[IRQ_TX_OVF]   = r_tx_ovf;
  end

  assign w_irq_clr = w_wr_irq_stat ? bus.wdata[3:0] : 4'h0;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_irq_en   <= '0;
      r_irq_stat <= '0;
      r_irq_lvl  <= IRQ_LVL_RST;
      r_irq      <= 1'b0;
    end else begin
      r_irq_lvl  <= w_irq_lvl;
      if (w_wr_irq_en) r_irq_en <= bus.wdata[3:0];
      r_irq_stat <= (r_irq_stat & ~w_irq_clr) | (w_irq_lvl & ~r_irq_lvl);
      r_irq      <= |(r_irq_stat & r_irq_en);
    end
  end

  assign bus.irq    = r_irq;
  assign w_wr_valid = w_wr_data || w_wr_status || w_wr_ctrl || w_wr_baud ||
                      w_wr_irq_en || w_wr_irq_stat;
  assign w_rd_valid = w_rd_data || w_rd_status || w_rd_ctrl || w_rd_baud ||
                      w_rd_irq_en || w_rd_irq_stat;
`else
  assign bus.irq    = 1'b0;
  assign w_wr_valid = w_wr_data || w_wr_status || w_wr_ctrl || w_wr_baud;
  assign w_rd_valid = w_rd_data || w_rd_status || w_rd_ctrl || w_rd_baud;
`endif

  always_comb begin
    bus.rdata = '0;
    if (!preset) begin
      if (w_rd_data && !w_rx_empty) bus.rdata = {24'h0, w_rx_head};
      if (w_rd_status)              bus.rdata = w_status;
      if (w_rd_ctrl)                bus.rdata = {24'h0, r_ctrl};
      if (w_rd_baud)                bus.rdata = {16'h0, r_baud};
`ifdef UART_REG_IRQ_EN
      if (w_rd_irq_en)              bus.rdata = {28'h0, r_irq_en};
      if (w_rd_irq_stat)            bus.rdata = {28'h0, r_irq_stat};
`endif
    end
  end

  assign bus.wadderr  = preset || !bus.wr_en || w_wr_valid;
  assign bus.radderr  = preset || !bus.host_read_data || w_rd_valid;
  assign bus.tx_data  = w_tx_head;
  assign bus.tx_valid = w_tx_valid;
  assign bus.baud_div = r_baud;
  assign bus.ctrl_o   = r_ctrl;

endmodule
